// File: rtl/ahb_arbiter_2m_if.sv
// ahb_arbiter_2m_if
//
// Bundles the two-master AHB-Lite arbitration bus as seen by the arbiter.
// The arbiter connects through the slave modport. The environment (bus
// masters, slave fabric or a testbench) connects through the master modport.
//
// Signal groups:
//   m0_* : master 0 (data port) request, address/control, write data, grant
//   m1_* : master 1 (instruction port), same set as m0_*
//   s_*  : muxed address/control/write data toward the decoder and slaves,
//          plus slave ready and read data coming back
//   m_*  : read data and ready broadcast to both masters
//   hmaster : address-phase owner (00 none, 01 M0, 10 M1)

interface ahb_arbiter_2m_if;

    // master 0
    logic        m0_hbusreq;
    logic [31:0] m0_haddr;
    logic [1:0]  m0_htrans;
    logic [2:0]  m0_hsize;
    logic [2:0]  m0_hburst;
    logic        m0_hwrite;
    logic [31:0] m0_hwdata;
    logic        m0_hgrant;

    // master 1
    logic        m1_hbusreq;
    logic [31:0] m1_haddr;
    logic [1:0]  m1_htrans;
    logic [2:0]  m1_hsize;
    logic [2:0]  m1_hburst;
    logic        m1_hwrite;
    logic [31:0] m1_hwdata;
    logic        m1_hgrant;

    // shared slave side
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic        s_hwrite;
    logic [31:0] s_hwdata;
    logic        s_hready;
    logic [31:0] s_hrdata;

    // broadcast back to the masters
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic [1:0]  hmaster;

    modport slave (
        input  m0_hbusreq, m0_haddr, m0_htrans, m0_hsize, m0_hburst, m0_hwrite, m0_hwdata,
        output m0_hgrant,
        input  m1_hbusreq, m1_haddr, m1_htrans, m1_hsize, m1_hburst, m1_hwrite, m1_hwdata,
        output m1_hgrant,
        output s_haddr, s_htrans, s_hsize, s_hburst, s_hwrite, s_hwdata,
        input  s_hready, s_hrdata,
        output m_hrdata, m_hready, hmaster
    );

    modport master (
        output m0_hbusreq, m0_haddr, m0_htrans, m0_hsize, m0_hburst, m0_hwrite, m0_hwdata,
        input  m0_hgrant,
        output m1_hbusreq, m1_haddr, m1_htrans, m1_hsize, m1_hburst, m1_hwrite, m1_hwdata,
        input  m1_hgrant,
        input  s_haddr, s_htrans, s_hsize, s_hburst, s_hwrite, s_hwdata,
        output s_hready, s_hrdata,
        input  m_hrdata, m_hready, hmaster
    );

endinterface

// File: rtl/ahb_arbiter_2m.sv
// ahb_arbiter_2m
//
// Two-master AHB-Lite arbiter and master-side multiplexer. Master 0 is the
// core's data-port interface, master 1 the instruction-port interface.
// Grants are registered (decoded from the address-phase owner register), the
// address/control bus is muxed from the address-phase owner and the write
// data bus from the data-phase owner, so a handover never takes the old
// owner's write data from the new owner.
//
// Parameters:
//   RR_EN    : 0 = fixed priority, M0 wins ties; 1 = round robin, the master
//              that owned the bus last loses a tie
//   MAX_HOLD : cycles an owner may keep the bus while the other master is
//              requesting before ownership is forced over; 0 = no limit
//
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : ahb_arbiter_2m_if.slave -- master requests/grants, muxed slave
//         bus, slave ready/read data and their broadcast to the masters

module ahb_arbiter_2m #(
    parameter int RR_EN    = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    ahb_arbiter_2m_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    // The hold counter only has to reach MAX_HOLD-1.
    localparam int                HOLD_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam bit                RR_ON     = (RR_EN != 0);

    owner_e            addr_owner;
    owner_e            addr_owner_next;
    owner_e            data_owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              rr_last;
    logic              rr_last_next;

    owner_e            winner;
    owner_e            other_id;
    logic              own_req;
    logic              other_req;
    logic              hold_expired;

    // Who would win a fresh arbitration from the current requests. On a tie
    // round robin hands the bus to the master that did not own it last.
    always_comb begin
        winner = OWN_NONE;
        if (bus.m0_hbusreq && bus.m1_hbusreq) begin
            if (RR_ON && !rr_last) begin
                winner = OWN_M1;
            end else begin
                winner = OWN_M0;
            end
        end else if (bus.m0_hbusreq) begin
            winner = OWN_M0;
        end else if (bus.m1_hbusreq) begin
            winner = OWN_M1;
        end
    end

    // Current owner's own request and the competing master's request.
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        other_id  = OWN_NONE;
        case (addr_owner)
            OWN_M0: begin
                own_req   = bus.m0_hbusreq;
                other_req = bus.m1_hbusreq;
                other_id  = OWN_M1;
            end
            OWN_M1: begin
                own_req   = bus.m1_hbusreq;
                other_req = bus.m0_hbusreq;
                other_id  = OWN_M0;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
                other_id  = OWN_NONE;
            end
        endcase
    end

    assign hold_expired = HOLD_EN && (hold_cnt == HOLD_LAST);

    // Next owner, hold counter and round-robin pointer. A releasing owner
    // hands straight to a requesting competitor without passing through
    // NONE, and the hold limit forces a handover only while the competitor
    // is actually waiting.
    always_comb begin
        addr_owner_next = addr_owner;
        hold_cnt_next   = hold_cnt;
        rr_last_next    = rr_last;

        if (addr_owner == OWN_NONE) begin
            addr_owner_next = winner;
        end else if (!own_req) begin
            addr_owner_next = other_req ? other_id : OWN_NONE;
        end else if (other_req && hold_expired) begin
            addr_owner_next = other_id;
        end

        if (addr_owner_next != addr_owner) begin
            hold_cnt_next = '0;
        end else if (other_req) begin
            hold_cnt_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HOLD_ONE;
        end else begin
            hold_cnt_next = '0;
        end

        if ((addr_owner_next != addr_owner) && (addr_owner_next != OWN_NONE)) begin
            rr_last_next = (addr_owner_next == OWN_M1);
        end
    end

    // Ownership state. Nothing moves while the slave stretches the data
    // phase, so the data-phase owner always trails the address-phase owner
    // by exactly one completed transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_owner <= OWN_NONE;
            data_owner <= OWN_NONE;
            hold_cnt   <= '0;
            rr_last    <= 1'b1;
        end else if (bus.s_hready) begin
            addr_owner <= addr_owner_next;
            data_owner <= addr_owner;
            hold_cnt   <= hold_cnt_next;
            rr_last    <= rr_last_next;
        end
    end

    // Address/control mux; an unowned bus shows IDLE with zeroed fields.
    always_comb begin
        bus.s_haddr  = '0;
        bus.s_htrans = 2'b00;
        bus.s_hsize  = '0;
        bus.s_hburst = '0;
        bus.s_hwrite = 1'b0;
        case (addr_owner)
            OWN_M0: begin
                bus.s_haddr  = bus.m0_haddr;
                bus.s_htrans = bus.m0_htrans;
                bus.s_hsize  = bus.m0_hsize;
                bus.s_hburst = bus.m0_hburst;
                bus.s_hwrite = bus.m0_hwrite;
            end
            OWN_M1: begin
                bus.s_haddr  = bus.m1_haddr;
                bus.s_htrans = bus.m1_htrans;
                bus.s_hsize  = bus.m1_hsize;
                bus.s_hburst = bus.m1_hburst;
                bus.s_hwrite = bus.m1_hwrite;
            end
            default: begin
                bus.s_haddr  = '0;
                bus.s_htrans = 2'b00;
                bus.s_hsize  = '0;
                bus.s_hburst = '0;
                bus.s_hwrite = 1'b0;
            end
        endcase
    end

    // Write data follows the data-phase owner, not the address-phase owner.
    always_comb begin
        bus.s_hwdata = '0;
        case (data_owner)
            OWN_M0:  bus.s_hwdata = bus.m0_hwdata;
            OWN_M1:  bus.s_hwdata = bus.m1_hwdata;
            default: bus.s_hwdata = '0;
        endcase
    end

    assign bus.m0_hgrant = (addr_owner == OWN_M0);
    assign bus.m1_hgrant = (addr_owner == OWN_M1);
    assign bus.hmaster   = addr_owner;
    assign bus.m_hrdata  = bus.s_hrdata;
    assign bus.m_hready  = bus.s_hready;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// tb_ahb_arbiter_2m
//
// Drives two arbiters from the same stimulus: dut_a with fixed priority and
// a hold limit of 4, dut_b with round robin and no hold limit. A behavioural
// model predicts each arbiter's outputs when stimulus is driven; the
// predictions are queued and compared after the following clock edge.
// Directed scenarios add hand-derived constant expectations on top.

module tb_ahb_arbiter_2m;

    localparam int A_RR   = 0;
    localparam int A_HOLD = 4;
    localparam int B_RR   = 1;
    localparam int B_HOLD = 0;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    // Fixed, distinct control fields for each master.
    localparam logic [1:0] M0_TRANS = 2'b10;
    localparam logic [2:0] M0_SIZE  = 3'b010;
    localparam logic [2:0] M0_BURST = 3'b001;
    localparam logic       M0_WRITE = 1'b1;
    localparam logic [1:0] M1_TRANS = 2'b11;
    localparam logic [2:0] M1_SIZE  = 3'b001;
    localparam logic [2:0] M1_BURST = 3'b011;
    localparam logic       M1_WRITE = 1'b0;

    typedef struct {
        logic [1:0] own;
        logic [1:0] dow;
        int         cnt;
        logic       rrl;
    } model_t;

    typedef struct {
        int          dut;
        logic        g0;
        logic        g1;
        logic [1:0]  hm;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic [6:0]  ctrl;
        logic [31:0] hwdata;
        logic [31:0] hrdata;
        logic        hready;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     n_tests;
    int     n_fail;
    int     cyc;
    model_t mdl_a;
    model_t mdl_b;
    exp_t   exp_q[$];
    logic [31:0] last_a0;
    logic [31:0] last_a1;

    ahb_arbiter_2m_if ifa();
    ahb_arbiter_2m_if ifb();

    ahb_arbiter_2m #(.RR_EN(A_RR), .MAX_HOLD(A_HOLD)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (ifa)
    );

    ahb_arbiter_2m #(.RR_EN(B_RR), .MAX_HOLD(B_HOLD)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference behaviour of one arbiter across one clock edge.
    function automatic model_t modelNext(model_t m, logic r0, logic r1, logic rdy,
                                         logic rstn, int rr_en, int max_hold);
        model_t     n;
        logic [1:0] want;
        logic       mine;
        logic       other;
        logic [1:0] other_master;
        n = m;
        if (!rstn) begin
            n.own = OWN_NONE;
            n.dow = OWN_NONE;
            n.cnt = 0;
            n.rrl = 1'b1;
            return n;
        end
        if (!rdy) return n;
        mine         = 1'b0;
        other        = 1'b0;
        other_master = OWN_NONE;
        if (m.own == OWN_M0) begin
            mine = r0; other = r1; other_master = OWN_M1;
        end else if (m.own == OWN_M1) begin
            mine = r1; other = r0; other_master = OWN_M0;
        end
        if (m.own == OWN_NONE) begin
            if (r0 && r1)  want = (rr_en != 0 && m.rrl == 1'b0) ? OWN_M1 : OWN_M0;
            else if (r0)   want = OWN_M0;
            else if (r1)   want = OWN_M1;
            else           want = OWN_NONE;
        end else if (!mine) begin
            want = other ? other_master : OWN_NONE;
        end else if (other && max_hold != 0 && m.cnt == max_hold - 1) begin
            want = other_master;
        end else begin
            want = m.own;
        end
        n.dow = m.own;
        n.own = want;
        if (want != m.own) begin
            n.cnt = 0;
            if (want != OWN_NONE) n.rrl = (want == OWN_M1);
        end else if (other && m.cnt < max_hold - 1) begin
            n.cnt = m.cnt + 1;
        end else if (!other) begin
            n.cnt = 0;
        end
        return n;
    endfunction

    function automatic exp_t mkExp(int d, model_t n, logic [31:0] a0, logic [31:0] w0,
                                   logic [31:0] a1, logic [31:0] w1,
                                   logic [31:0] rdata, logic rdy);
        exp_t e;
        e.dut    = d;
        e.g0     = (n.own == OWN_M0);
        e.g1     = (n.own == OWN_M1);
        e.hm     = n.own;
        e.htrans = (n.own == OWN_M0) ? M0_TRANS : (n.own == OWN_M1) ? M1_TRANS : 2'b00;
        e.haddr  = (n.own == OWN_M0) ? a0 : (n.own == OWN_M1) ? a1 : 32'h0;
        e.ctrl   = (n.own == OWN_M0) ? {M0_SIZE, M0_BURST, M0_WRITE} :
                   (n.own == OWN_M1) ? {M1_SIZE, M1_BURST, M1_WRITE} : 7'h0;
        e.hwdata = (n.dow == OWN_M0) ? w0 : (n.dow == OWN_M1) ? w1 : 32'h0;
        e.hrdata = rdata;
        e.hready = rdy;
        return e;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue predictions.
    task automatic applyStimulus(input logic r0, input logic r1, input logic rdy, input logic rstn,
                                 input logic [31:0] a0, input logic [31:0] w0,
                                 input logic [31:0] a1, input logic [31:0] w1);
        logic [31:0] rdata;
        @(negedge clk);
        rdata = $urandom;
        rst_n = rstn;
        ifa.m0_hbusreq = r0;  ifb.m0_hbusreq = r0;
        ifa.m0_haddr   = a0;  ifb.m0_haddr   = a0;
        ifa.m0_hwdata  = w0;  ifb.m0_hwdata  = w0;
        ifa.m1_hbusreq = r1;  ifb.m1_hbusreq = r1;
        ifa.m1_haddr   = a1;  ifb.m1_haddr   = a1;
        ifa.m1_hwdata  = w1;  ifb.m1_hwdata  = w1;
        ifa.s_hready   = rdy; ifb.s_hready   = rdy;
        ifa.s_hrdata   = rdata; ifb.s_hrdata = rdata;
        last_a0 = a0;
        last_a1 = a1;
        mdl_a = modelNext(mdl_a, r0, r1, rdy, rstn, A_RR, A_HOLD);
        mdl_b = modelNext(mdl_b, r0, r1, rdy, rstn, B_RR, B_HOLD);
        exp_q.push_back(mkExp(0, mdl_a, a0, w0, a1, w1, rdata, rdy));
        exp_q.push_back(mkExp(1, mdl_b, a0, w0, a1, w1, rdata, rdy));
        cyc++;
    endtask

    task automatic sampleObs(input int d, output exp_t o);
        o.dut = d;
        if (d == 0) begin
            o.g0 = ifa.m0_hgrant; o.g1 = ifa.m1_hgrant; o.hm = ifa.hmaster;
            o.htrans = ifa.s_htrans; o.haddr = ifa.s_haddr;
            o.ctrl = {ifa.s_hsize, ifa.s_hburst, ifa.s_hwrite};
            o.hwdata = ifa.s_hwdata; o.hrdata = ifa.m_hrdata; o.hready = ifa.m_hready;
        end else begin
            o.g0 = ifb.m0_hgrant; o.g1 = ifb.m1_hgrant; o.hm = ifb.hmaster;
            o.htrans = ifb.s_htrans; o.haddr = ifb.s_haddr;
            o.ctrl = {ifb.s_hsize, ifb.s_hburst, ifb.s_hwrite};
            o.hwdata = ifb.s_hwdata; o.hrdata = ifb.m_hrdata; o.hready = ifb.m_hready;
        end
    endtask

    // After the rising edge, pop both predictions and compare.
    task automatic checkCycle();
        exp_t  e;
        exp_t  o;
        string dn;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e  = exp_q.pop_front();
                dn = (e.dut == 0) ? "a" : "b";
                sampleObs(e.dut, o);
                checkOutput({dn, ".m0_hgrant"}, {31'b0, o.g0},     {31'b0, e.g0});
                checkOutput({dn, ".m1_hgrant"}, {31'b0, o.g1},     {31'b0, e.g1});
                checkOutput({dn, ".hmaster"},   {30'b0, o.hm},     {30'b0, e.hm});
                checkOutput({dn, ".s_htrans"},  {30'b0, o.htrans}, {30'b0, e.htrans});
                checkOutput({dn, ".s_haddr"},   o.haddr,           e.haddr);
                checkOutput({dn, ".s_ctrl"},    {25'b0, o.ctrl},   {25'b0, e.ctrl});
                checkOutput({dn, ".s_hwdata"},  o.hwdata,          e.hwdata);
                checkOutput({dn, ".m_hrdata"},  o.hrdata,          e.hrdata);
                checkOutput({dn, ".m_hready"},  {31'b0, o.hready}, {31'b0, e.hready});
            end
        end
    endtask

    task automatic stepDefault(input logic r0, input logic r1, input logic rdy, input logic rstn);
        applyStimulus(r0, r1, rdy, rstn,
                      32'h1000_0000 + 32'(cyc << 2), 32'hA000_0000 | 32'(cyc),
                      32'h2000_0000 + 32'(cyc << 2), 32'hB000_0000 | 32'(cyc));
        checkCycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        mdl_a   = '{own: OWN_NONE, dow: OWN_NONE, cnt: 0, rrl: 1'b1};
        mdl_b   = '{own: OWN_NONE, dow: OWN_NONE, cnt: 0, rrl: 1'b1};
        ifa.m0_hbusreq = 1'b0; ifa.m0_haddr = '0; ifa.m0_htrans = M0_TRANS; ifa.m0_hsize = M0_SIZE;
        ifa.m0_hburst = M0_BURST; ifa.m0_hwrite = M0_WRITE; ifa.m0_hwdata = '0;
        ifa.m1_hbusreq = 1'b0; ifa.m1_haddr = '0; ifa.m1_htrans = M1_TRANS; ifa.m1_hsize = M1_SIZE;
        ifa.m1_hburst = M1_BURST; ifa.m1_hwrite = M1_WRITE; ifa.m1_hwdata = '0;
        ifa.s_hready = 1'b1; ifa.s_hrdata = '0;
        ifb.m0_hbusreq = 1'b0; ifb.m0_haddr = '0; ifb.m0_htrans = M0_TRANS; ifb.m0_hsize = M0_SIZE;
        ifb.m0_hburst = M0_BURST; ifb.m0_hwrite = M0_WRITE; ifb.m0_hwdata = '0;
        ifb.m1_hbusreq = 1'b0; ifb.m1_haddr = '0; ifb.m1_htrans = M1_TRANS; ifb.m1_hsize = M1_SIZE;
        ifb.m1_hburst = M1_BURST; ifb.m1_hwrite = M1_WRITE; ifb.m1_hwdata = '0;
        ifb.s_hready = 1'b1; ifb.s_hrdata = '0;

        // Reset held with both masters requesting.
        stepDefault(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rst.m0_hgrant", {31'b0, ifa.m0_hgrant}, 32'd0);
        checkOutput("rst.s_htrans",  {30'b0, ifa.s_htrans},  32'd0);
        checkOutput("rst.hmaster",   {30'b0, ifa.hmaster},   32'd0);
        stepDefault(1'b1, 1'b1, 1'b1, 1'b0);

        // Release: both request, M0 is granted one cycle later.
        stepDefault(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("prio.m0_hgrant", {31'b0, ifa.m0_hgrant}, 32'd1);
        checkOutput("prio.hmaster",   {30'b0, ifa.hmaster},   {30'b0, OWN_M0});
        checkOutput("rr_first.hmaster", {30'b0, ifb.hmaster}, {30'b0, OWN_M0});

        // M0 drops, M1 takes over and drives the address bus.
        stepDefault(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("drop.m1_hgrant", {31'b0, ifa.m1_hgrant}, 32'd1);
        checkOutput("drop.s_haddr",   ifa.s_haddr,            last_a1);

        // Release and request in the same cycle: direct handover.
        stepDefault(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("handover.hmaster", {30'b0, ifa.hmaster}, {30'b0, OWN_M0});

        // Stall: M0 releases while the slave holds HREADY low.
        for (int i = 0; i < 3; i++) begin
            stepDefault(1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("stall.m0_hgrant", {31'b0, ifa.m0_hgrant}, 32'd1);
        end
        stepDefault(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("unstall.m1_hgrant", {31'b0, ifa.m1_hgrant}, 32'd1);

        // Write handover: M0's last address phase while M1 takes over.
        stepDefault(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1,
                      32'h0000_1000, 32'hDEAD_BEEF, 32'h2000_0040, 32'h1234_5678);
        checkCycle();
        checkOutput("wr_handover.s_hwdata", ifa.s_hwdata, 32'hDEAD_BEEF);
        checkOutput("wr_handover.s_haddr",  ifa.s_haddr,  32'h2000_0040);

        // Hold limit on dut_a: M1 owns 4 cycles, then M0 for 4, and so on.
        for (int k = 1; k <= 16; k++) begin
            stepDefault(1'b1, 1'b1, 1'b1, 1'b1);
            checkOutput("hold.hmaster", {30'b0, ifa.hmaster},
                        (((k / 4) % 2) == 0) ? {30'b0, OWN_M1} : {30'b0, OWN_M0});
        end

        // Both release while both were requesting: bus goes idle.
        stepDefault(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("idle.hmaster", {30'b0, ifa.hmaster}, 32'd0);

        // Round robin on dut_b alternates; fixed priority on dut_a does not.
        for (int k = 0; k < 4; k++) begin
            stepDefault(1'b1, 1'b1, 1'b1, 1'b1);
            checkOutput("rr.hmaster", {30'b0, ifb.hmaster},
                        ((k % 2) == 0) ? {30'b0, OWN_M0} : {30'b0, OWN_M1});
            checkOutput("fixed.hmaster", {30'b0, ifa.hmaster}, {30'b0, OWN_M0});
            stepDefault(1'b0, 1'b0, 1'b1, 1'b1);
        end

        // Reset mid-transfer takes effect without waiting for a clock edge.
        stepDefault(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0,
                      32'h1000_0000 + 32'(cyc << 2), 32'hA000_0000 | 32'(cyc),
                      32'h2000_0000 + 32'(cyc << 2), 32'hB000_0000 | 32'(cyc));
        #1;
        checkOutput("async_rst.m0_hgrant", {31'b0, ifa.m0_hgrant}, 32'd0);
        checkOutput("async_rst.s_htrans",  {30'b0, ifa.s_htrans},  32'd0);
        checkOutput("async_rst.b_hmaster", {30'b0, ifb.hmaster},   32'd0);
        checkCycle();
        stepDefault(1'b1, 1'b1, 1'b1, 1'b1);

        // Random traffic, stalls and occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            stepDefault(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
        end

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
